// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter with valid/ready input and
// a one-entry holding register so back-to-back frames leave tx with no gap.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
// Ports: clk_3125, rst (sync, active-high), tx_data/tx_valid/tx_ready
// (handshake), parity_type (0 even, 1 odd), tx (line), tx_busy, tx_done.
module uart_tx_stream #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 14,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk_3125,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_type,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     baud;
  logic [BW-1:0]     bitc;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full;
  logic              tx_q;

  logic              bit_end;
  logic              last_data;
  logic              last_stop;
  logic              fire;
  logic              frame_end;
  logic              load_now;
  logic              from_hold;
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] sh_nx;
  logic              head;
  logic              head_nx;

`ifdef UART_TX_PARITY_EN
  logic hold_p;
  logic par_q;
  logic ld_par;
`else
  logic unused_parity;
  assign unused_parity = parity_type;
`endif

  assign bit_end   = (baud == CW'(CLKS_PER_BIT - 1));
  assign last_data = (bitc == BW'(DATA_W - 1));
  assign last_stop = (bitc == BW'(STOP_BITS - 1));
  assign fire      = tx_valid && !hold_full;
  assign frame_end = (state == S_STOP) && bit_end && last_stop;

  // A queued word wins at frame end; otherwise a live handshake
  // either starts a frame (idle / frame end) or fills holding.
  assign from_hold = frame_end && hold_full;
  assign load_now  = ((state == S_IDLE) && fire) ||
                     (frame_end && (hold_full || fire));
  assign ld_word   = from_hold ? hold_q : tx_data;

`ifdef UART_TX_PARITY_EN
  assign ld_par = (^ld_word) ^ (from_hold ? hold_p : parity_type);
`endif

  always_comb begin
    head    = shreg[0];
    sh_nx   = {1'b0, shreg[DATA_W-1:1]};
    head_nx = sh_nx[0];
    if (MSB_FIRST != 0) begin
      head    = shreg[DATA_W-1];
      sh_nx   = {shreg[DATA_W-2:0], 1'b0};
      head_nx = sh_nx[DATA_W-1];
    end
  end

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
`ifdef UART_TX_PARITY_EN
      hold_p    <= 1'b0;
`endif
    end else if (fire && tx_busy && !frame_end) begin
      hold_full <= 1'b1;
      hold_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
      hold_p    <= parity_type;
`endif
    end else if (from_hold) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state <= S_IDLE;
      baud  <= '0;
      bitc  <= '0;
      shreg <= '0;
      tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (load_now) begin
      state <= S_START;
      baud  <= '0;
      bitc  <= '0;
      shreg <= ld_word;
      tx_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= ld_par;
`endif
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        baud <= baud + CW'(1);
      end else begin
        baud <= '0;
        case (state)
          S_START: begin
            state <= S_DATA;
            bitc  <= '0;
            tx_q  <= head;
          end
          S_DATA: begin
            if (last_data) begin
              bitc  <= '0;
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= par_q;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bitc  <= bitc + BW'(1);
              shreg <= sh_nx;
              tx_q  <= head_nx;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            bitc  <= '0;
            tx_q  <= 1'b1;
          end
`endif
          S_STOP: begin
            if (last_stop) begin
              state <= S_IDLE;
              bitc  <= '0;
              tx_q  <= 1'b1;
            end else begin
              bitc  <= bitc + BW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state != S_IDLE);
  assign tx_done  = frame_end;
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed frames with literal expectations plus
// randomized traffic on two configurations against a frame-level model.
module tb_uart_tx_stream;

  logic clk_3125 = 1'b0;
  always #5 clk_3125 = ~clk_3125;

  logic       rst = 1'b0;
  logic [7:0] d0 = '0;
  logic       v0 = 1'b0;
  logic       p0 = 1'b0;
  logic       r0, tx0, b0, dn0;
  logic [6:0] d1 = '0;
  logic       v1 = 1'b0;
  logic       p1 = 1'b0;
  logic       r1, tx1, b1, dn1;

  int checks = 0;
  int failures = 0;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL0 = (1 + 8 + PB + 1) * 14;
  localparam int FL1 = (1 + 7 + PB + 2) * 4;

  uart_tx_stream u0 (
    .clk_3125(clk_3125), .rst(rst),
    .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
    .parity_type(p0), .tx(tx0), .tx_busy(b0), .tx_done(dn0)
  );

  uart_tx_stream #(
    .DATA_W(7), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(0)
  ) u1 (
    .clk_3125(clk_3125), .rst(rst),
    .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .parity_type(p1), .tx(tx1), .tx_busy(b1), .tx_done(dn1)
  );

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame-level model: each frame is a list of line bits; the position
  // inside the frame (in clock cycles) selects the bit on the line.
  int DW[2] = '{8, 7};
  int CP[2] = '{14, 4};
  int SB[2] = '{1, 2};
  int MF[2] = '{1, 0};
  bit       m_act[2];
  int       m_pos[2];
  bit       m_bits[2][16];
  bit       m_hv[2];
  logic [8:0] m_hw[2];
  bit       m_hp[2];
  bit       en = 1'b0;

  function automatic int flen(int ch);
    return (1 + DW[ch] + PB + SB[ch]) * CP[ch];
  endfunction

  task automatic build(int ch, logic [8:0] w, bit pt);
    int k;
    bit b;
    bit par;
    par = 1'b0;
    m_bits[ch][0] = 1'b0;
    for (int i = 0; i < DW[ch]; i++) begin
      b = (MF[ch] != 0) ? w[DW[ch]-1-i] : w[i];
      m_bits[ch][1+i] = b;
      par ^= b;
    end
    k = 1 + DW[ch];
    if (PB == 1) begin
      m_bits[ch][k] = par ^ pt;
      k++;
    end
    for (int i = 0; i < SB[ch]; i++) m_bits[ch][k+i] = 1'b1;
    m_act[ch] = 1'b1;
    m_pos[ch] = 0;
  endtask

  task automatic step(int ch, bit rs, bit v, logic [8:0] w, bit pt);
    bit fire;
    if (rs) begin
      m_act[ch] = 1'b0;
      m_hv[ch]  = 1'b0;
      m_pos[ch] = 0;
      return;
    end
    fire = v && !m_hv[ch];
    if (m_act[ch]) begin
      if (m_pos[ch] == flen(ch) - 1) begin
        if (m_hv[ch]) begin
          build(ch, m_hw[ch], m_hp[ch]);
          m_hv[ch] = 1'b0;
        end else if (fire) begin
          build(ch, w, pt);
        end else begin
          m_act[ch] = 1'b0;
        end
      end else begin
        m_pos[ch]++;
        if (fire) begin
          m_hv[ch] = 1'b1;
          m_hw[ch] = w;
          m_hp[ch] = pt;
        end
      end
    end else if (fire) begin
      build(ch, w, pt);
    end
  endtask

  always @(posedge clk_3125) begin
    step(0, rst, v0, {1'b0, d0}, p0);
    step(1, rst, v1, {2'b0, d1}, p1);
    if (rst) en = 1'b1;
  end

  always @(negedge clk_3125) begin
    if (en) begin
      for (int ch = 0; ch < 2; ch++) begin
        logic etx, ebusy, edone, erdy;
        logic atx, abusy, adone, ardy;
        etx   = m_act[ch] ? m_bits[ch][m_pos[ch] / CP[ch]] : 1'b1;
        ebusy = m_act[ch];
        edone = m_act[ch] && (m_pos[ch] == flen(ch) - 1);
        erdy  = !m_hv[ch];
        atx   = (ch == 0) ? tx0 : tx1;
        abusy = (ch == 0) ? b0 : b1;
        adone = (ch == 0) ? dn0 : dn1;
        ardy  = (ch == 0) ? r0 : r1;
        chk($sformatf("model ch%0d tx", ch), atx, etx);
        chk($sformatf("model ch%0d tx_busy", ch), abusy, ebusy);
        chk($sformatf("model ch%0d tx_done", ch), adone, edone);
        chk($sformatf("model ch%0d tx_ready", ch), ardy, erdy);
      end
    end
  end

  logic line[0:15];
  int   done_at;
  int   npulse;
  int   rdy_low;

  // Offer one word on u0 and watch the frame; returns at an idle cycle.
  task automatic frame0(logic [7:0] w, bit pt);
    v0 = 1'b1; d0 = w; p0 = pt;
    @(negedge clk_3125);
    v0 = 1'b0;
    done_at = -1; npulse = 0; rdy_low = 0;
    for (int c = 1; c <= FL0 + 3; c++) begin
      if (dn0) begin npulse++; done_at = c; end
      if (!r0) rdy_low++;
      if ((c - 1) % 14 == 7) line[(c - 1) / 14] = tx0;
      @(negedge clk_3125);
    end
  endtask

  initial begin
    int exp_a[11];
    int err_r, err_b, d1at, d2at, np, txs, txe;
    rst = 1'b1;
    repeat (3) @(negedge clk_3125);
    chk("reset tx", tx0, 1'b1);
    chk("reset tx_ready", r0, 1'b1);
    chk("reset tx_busy", b0, 1'b0);
    chk("reset tx_done", dn0, 1'b0);
    rst = 1'b0;
    @(negedge clk_3125);

    // 0xA5, even parity, MSB first
    frame0(8'hA5, 1'b0);
`ifdef UART_TX_PARITY_EN
    exp_a = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    chki("a5 done cycle", done_at, 154);
    for (int k = 0; k < 11; k++)
      chk($sformatf("a5 bit%0d", k), line[k], exp_a[k][0]);
`else
    exp_a = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    chki("a5 done cycle", done_at, 140);
    for (int k = 0; k < 10; k++)
      chk($sformatf("a5 bit%0d", k), line[k], exp_a[k][0]);
`endif
    chki("a5 done pulses", npulse, 1);
    chki("a5 ready low cycles", rdy_low, 0);

`ifdef UART_TX_PARITY_EN
    frame0(8'h00, 1'b1);
    chk("odd 00 parity", line[9], 1'b1);
    chki("odd 00 done", done_at, 154);
    frame0(8'hFF, 1'b1);
    chk("odd ff parity", line[9], 1'b1);
    chki("odd ff done", done_at, 154);
`endif

    // back-to-back 0x3C then 0xC3 offered in cycle 5
    v0 = 1'b1; d0 = 8'h3C; p0 = 1'b0;
    @(negedge clk_3125);
    v0 = 1'b0;
    err_r = 0; err_b = 0; d1at = -1; d2at = -1; np = 0;
    txs = -1; txe = -1;
    for (int c = 1; c <= 2 * FL0 + 4; c++) begin
      if (r0 !== ((c >= 6 && c <= FL0) ? 1'b0 : 1'b1)) err_r++;
      if (c <= 2 * FL0 && b0 !== 1'b1) err_b++;
      if (dn0) begin
        np++;
        if (np == 1) d1at = c; else d2at = c;
      end
      if (c == FL0) txe = int'(tx0);
      if (c == FL0 + 1) txs = int'(tx0);
      if (c == 5) begin v0 = 1'b1; d0 = 8'hC3; end
      if (c == 6) v0 = 1'b0;
      @(negedge clk_3125);
    end
    chki("b2b ready profile errors", err_r, 0);
    chki("b2b busy gaps", err_b, 0);
    chki("b2b done1 cycle", d1at, FL0);
    chki("b2b done2 cycle", d2at, 2 * FL0);
    chki("b2b done pulses", np, 2);
    chki("b2b last stop", txe, 1);
    chki("b2b second start", txs, 0);

    // reset in cycle 60 with a word in holding
    v0 = 1'b1; d0 = 8'h96; p0 = 1'b0;
    @(negedge clk_3125);
    v0 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 30) begin v0 = 1'b1; d0 = 8'h5A; end
      if (c == 31) begin
        v0 = 1'b0;
        chk("rst holding full", r0, 1'b0);
      end
      if (c == 60) rst = 1'b1;
      @(negedge clk_3125);
    end
    chk("rst tx", tx0, 1'b1);
    chk("rst busy", b0, 1'b0);
    chk("rst ready", r0, 1'b1);
    rst = 1'b0;
    err_b = 0;
    for (int c = 0; c < 200; c++) begin
      if (dn0 !== 1'b0 || tx0 !== 1'b1 || b0 !== 1'b0) err_b++;
      @(negedge clk_3125);
    end
    chki("rst no further frame", err_b, 0);

    // u1: 7 bits, LSB first, 2 stops, 4 clocks per bit
    v1 = 1'b1; d1 = 7'h55; p1 = 1'b0;
    @(negedge clk_3125);
    v1 = 1'b0;
    done_at = -1;
    for (int c = 1; c <= FL1 + 3; c++) begin
      if (dn1) done_at = c;
      if ((c - 1) % 4 == 2) line[(c - 1) / 4] = tx1;
      @(negedge clk_3125);
    end
    for (int k = 1; k <= 7; k++)
      chk($sformatf("w7 data%0d", k - 1), line[k], k[0]);
`ifdef UART_TX_PARITY_EN
    chk("w7 parity", line[8], 1'b0);
    chki("w7 done cycle", done_at, 44);
`else
    chki("w7 done cycle", done_at, 40);
`endif
    chk("w7 stop0", line[8 + PB], 1'b1);
    chk("w7 stop1", line[9 + PB], 1'b1);

    // randomized traffic on both instances
    for (int c = 0; c < 5000; c++) begin
      int dens;
      dens = (c / 700) % 3;
      v0 = ($urandom_range(0, 9) < 3 + 3 * dens);
      v1 = ($urandom_range(0, 9) < 2 + 3 * dens);
      d0 = 8'($urandom);
      d1 = 7'($urandom);
      p0 = 1'($urandom);
      p1 = 1'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk_3125);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (400) @(negedge clk_3125);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter that replaces the fixed 8-bit, 14-clocks-per-bit, start-bit-pulse serialiser on the 3.125 MHz domain. Adds configurable data width, bit order, stop-bit count and baud divisor, plus a valid/ready input handshake with a one-entry holding register, so consecutive frames leave the `tx` line with zero idle gap. Sits between the colour-sensor frame formatter and the board UART pin.

## Interface
- `DATA_W`, 8: payload bits per frame, 5–9.
- `CLKS_PER_BIT`, 14: clock cycles per serial bit, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `MSB_FIRST`, 1: 1 sends `tx_data[DATA_W-1]` first; 0 sends LSB first.

Ports:
- `clk_3125`  in  1  3.125 MHz clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_W  payload, sampled on handshake.
- `tx_valid`  in  1  payload offered.
- `tx_ready`  out  1  holding register empty; transfer when `tx_valid && tx_ready` at a rising edge.
- `parity_type`  in  1  0 = even, 1 = odd; sampled with `tx_data`.
- `tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse, last cycle of the final stop bit.

## Operation
- Frame order: start (0), DATA_W data bits in MSB_FIRST order, parity (if compiled in), STOP_BITS × 1.
- Parity: even → `^data`; odd → `~^data`. Computed from the captured word, not the live input.
- FSM: IDLE → START → DATA → PARITY → STOP → (IDLE or START).
  - PARITY is skipped when parity is compiled out.
  - Each state holds `tx` for exactly CLKS_PER_BIT cycles, timed by the baud counter.
  - The bit counter counts data bits 0..DATA_W-1 and stop bits 0..STOP_BITS-1.
- Handshake accepted while IDLE: word loads straight into the shifter and FSM enters START. Holding register stays empty, so `tx_ready` stays high.
- Handshake accepted while busy: word goes to the holding register and `tx_ready` drops the next cycle.
- Final cycle of the last stop bit:
  - Holding full: load the shifter from it, go to START, raise `tx_ready`.
  - Holding empty and handshake on this edge: load directly, go to START.
  - Otherwise: go to IDLE.
- `tx_valid` with `tx_ready` low: ignored. Data must be held by the source.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, counters 0, holding empty.
- Reset mid-frame: at that edge the frame is abandoned, holding contents are discarded, `tx`=1 from the next cycle, and no `tx_done` pulse is generated.

## Timing
- Accept at edge N from IDLE: `tx`=0 and `tx_busy`=1 from cycle N+1.
- Frame length F = (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 if parity is compiled in.
- `tx_done` is high in cycle N+F only.
- Back-to-back frames: next start bit begins at cycle N+F+1. `tx_busy` stays high and the line never returns to 1 between the stop bit and the next start bit.
- Throughput: one frame per F cycles.

## Configuration
- `UART_TX_PARITY_EN` defined: parity bit is inserted after the data bits and `parity_type` selects even/odd.
- Not defined: no parity state. Frame is start + data + stop, F = (1 + DATA_W + STOP_BITS) × CLKS_PER_BIT, and `parity_type` is ignored.

## Test plan
- Defaults, parity on, even, `tx_data`=0xA5 accepted at edge 0:
  - `tx` bits are 0,1,0,1,0,0,1,0,1,0,1, each 14 cycles long.
  - `tx_done` pulses only in cycle 154.
  - `tx_ready` stays high throughout.
- Odd parity, 0x00: parity bit = 1. Same setup with 0xFF: parity bit = 1. Both frames are 154 cycles.
- Back-to-back 0x3C, then 0xC3 presented at cycle 5:
  - 0xC3 is accepted at cycle 5 and `tx_ready` is low from cycle 6 to 154.
  - Second start bit begins at cycle 155.
  - `tx_busy` stays high from cycle 1 to 308.
  - `tx_done` pulses at cycles 154 and 308.
- `rst` asserted at cycle 60 of a frame with a word in holding:
  - `tx`=1 and `tx_busy`=0 from cycle 61.
  - `tx_ready`=1.
  - No `tx_done` pulse, and no further frame is sent.
- DATA_W=7, CLKS_PER_BIT=4, STOP_BITS=2, MSB_FIRST=0, parity on, even, data 0x55:
  - Data bits on the line are 1,0,1,0,1,0,1.
  - Parity bit = 0.
  - Two stop bits, F = 44, `tx_done` at cycle 44.
- `UART_TX_PARITY_EN` undefined, defaults, 0xA5: 10-bit frame, stop bit directly after the last data bit, `tx_done` at cycle 140.
